// File: rtl/alu_64bit.sv
// ----------------------------------------------------------------------------
// alu_64bit -- registered 64-bit ALU built from a ripple chain of 1-bit slices.
//
// Ports:
//   clk        : clock, all state updates on the rising edge
//   reset      : asynchronous, active-high; clears every output register
//   A, B       : operands
//   cntrl      : operation select
//                  000 B, 010 A+B, 011 A-B, 100 A&B, 101 A|B, 110 A^B,
//                  001/111 zero
//   result     : registered result (one cycle latency, one op per cycle)
//   negative   : registered result[63]
//   zero       : registered "result is all zeros"
//   overflow   : registered signed overflow, c[64] ^ c[63]
//   carry_out  : registered carry out of the top slice, c[64]
//
// Build option:
//   ALU_FLAG_GATING_EN : when defined, carry_out and overflow are forced to 0
//                        for every opcode other than add/sub. When undefined
//                        they are the raw carry-chain values for all opcodes.
//
// Also contains the leaf cells alu_1bit, mux2_1 and largeOR.
// ----------------------------------------------------------------------------
module alu_64bit #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    // Ripple carry chain: c[0] is the chain input, c[WIDTH] the carry out.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] result_c;
    logic             zero_c;
    logic             carry_c;
    logic             overflow_c;

    // Carry-in selects 0 for add and 1 for subtract (two's complement of B).
    mux2_1 u_cin_mux (
        .i   (2'b10),
        .sel (cntrl[0]),
        .out (c[0])
    );

    // One slice per bit; every slice sees the full opcode.
    for (genvar j = 0; j < WIDTH; j++) begin : g_slice
        alu_1bit u_slice (
            .a        (A[j]),
            .b        (B[j]),
            .carryIn  (c[j]),
            .selector (cntrl),
            .carryOut (c[j+1]),
            .result   (result_c[j])
        );
    end

    largeOR #(.WIDTH(WIDTH)) u_zero_detect (
        .in         (result_c),
        .zeroOutput (zero_c)
    );

    // Flag derivation from the top of the carry chain.
`ifdef ALU_FLAG_GATING_EN
    logic arith_c;
    assign arith_c    = ~cntrl[2] & cntrl[1];
    assign carry_c    = c[WIDTH] & arith_c;
    assign overflow_c = (c[WIDTH] ^ c[WIDTH-1]) & arith_c;
`else
    assign carry_c    = c[WIDTH];
    assign overflow_c = c[WIDTH] ^ c[WIDTH-1];
`endif

    // Output register: result and all flags captured together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result    <= '0;
            negative  <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            result    <= result_c;
            negative  <= result_c[WIDTH-1];
            zero      <= zero_c;
            overflow  <= overflow_c;
            carry_out <= carry_c;
        end
    end

endmodule

// ----------------------------------------------------------------------------
// alu_1bit -- one ALU bit slice.
//   a, b      : operand bits
//   carryIn   : carry from the slice below
//   selector  : operation select (same encoding as alu_64bit.cntrl)
//   carryOut  : carry of a + (selector[0] ? ~b : b) + carryIn, for any opcode
//   result    : selected operation output bit
// ----------------------------------------------------------------------------
module alu_1bit (
    input  logic       a,
    input  logic       b,
    input  logic       carryIn,
    input  logic [2:0] selector,
    output logic       carryOut,
    output logic       result
);

    logic b_eff;
    logic sum;

    // B is inverted for subtract; the chain runs for every opcode.
    assign b_eff    = b ^ selector[0];
    assign sum      = a ^ b_eff ^ carryIn;
    assign carryOut = (a & b_eff) | (a & carryIn) | (b_eff & carryIn);

    // Operation select; pass-through uses the un-inverted B.
    always_comb begin
        result = 1'b0;
        case (selector)
            3'b000:  result = b;
            3'b010:  result = sum;
            3'b011:  result = sum;
            3'b100:  result = a & b;
            3'b101:  result = a | b;
            3'b110:  result = a ^ b;
            default: result = 1'b0;
        endcase
    end

endmodule

// ----------------------------------------------------------------------------
// mux2_1 -- 2:1 multiplexer.
//   i   : data inputs, i[0] selected when sel=0, i[1] when sel=1
//   sel : select
//   out : selected bit
// ----------------------------------------------------------------------------
module mux2_1 (
    input  logic [1:0] i,
    input  logic       sel,
    output logic       out
);

    assign out = sel ? i[1] : i[0];

endmodule

// ----------------------------------------------------------------------------
// largeOR -- wide zero detector.
//   in         : vector to test
//   zeroOutput : 1 when every bit of in is 0
// ----------------------------------------------------------------------------
module largeOR #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] in,
    output logic             zeroOutput
);

    assign zeroOutput = ~(|in);

endmodule

// File: tb/tb_alu_64bit.sv
// ----------------------------------------------------------------------------
// tb_alu_64bit -- scoreboard bench for alu_64bit.
// A driver applies directed vectors on the falling edge and queues the
// hand-computed response; a monitor pops and compares just after each
// rising edge. Reset behaviour is checked directly by the driver.
// ----------------------------------------------------------------------------
module tb_alu_64bit;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;

`ifdef ALU_FLAG_GATING_EN
    localparam bit GATED = 1'b1;
`else
    localparam bit GATED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] A = '0;
    logic [63:0] B = '0;
    logic [2:0]  cntrl = 3'b000;
    logic [63:0] result;
    logic        negative;
    logic        zero;
    logic        overflow;
    logic        carry_out;

    typedef struct {
        string       name;
        logic [63:0] res;
        logic        n;
        logic        z;
        logic        v;
        logic        c;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alu_64bit #(.WIDTH(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .B         (B),
        .cntrl     (cntrl),
        .result    (result),
        .negative  (negative),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic compare(input exp_t e);
        checks++;
        if (result !== e.res || negative !== e.n || zero !== e.z ||
            overflow !== e.v || carry_out !== e.c) begin
            errors++;
            $display("FAIL %s: got res=%h n=%b z=%b v=%b c=%b, expected res=%h n=%b z=%b v=%b c=%b",
                     e.name, result, negative, zero, overflow, carry_out,
                     e.res, e.n, e.z, e.v, e.c);
        end
    endtask

    task automatic check_now(input string name, input logic [63:0] r,
                             input logic n, input logic z, input logic v, input logic c);
        exp_t e;
        e.name = name; e.res = r; e.n = n; e.z = z; e.v = v; e.c = c;
        compare(e);
    endtask

    // Apply one operation on the falling edge and queue its expected response.
    task automatic issue(input string name, input logic [2:0] op,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] r, input logic n, input logic z,
                         input logic v, input logic c);
        exp_t e;
        @(negedge clk);
        A = a; B = b; cntrl = op;
        e.name = name; e.res = r; e.n = n; e.z = z; e.v = v; e.c = c;
        sb.push_back(e);
    endtask

    // Monitor: output is valid every cycle, one cycle after the inputs.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            compare(e);
        end
    end

    initial begin
        #2 reset = 1'b1;
        #1 check_now("reset_init", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2 check_now("reset_held", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk) reset = 1'b0;

        //     name          op      A        B          result          n     z     v     c
        issue("add_msb",    3'b010, MSB,     MSB,       64'd0,          1'b0, 1'b1, 1'b1, 1'b1);
        issue("sub_3_2",    3'b011, 64'd3,   64'd2,     64'd1,          1'b0, 1'b0, 1'b0, 1'b1);
        issue("sub_1_1",    3'b011, 64'd1,   64'd1,     64'd0,          1'b0, 1'b1, 1'b0, 1'b1);
        issue("pass_b",     3'b000, ONES,    ONES,      ONES,           1'b1, 1'b0, 1'b0, ~GATED);
        issue("or_ones",    3'b101, 64'd0,   ONES,      ONES,           1'b1, 1'b0, 1'b0, 1'b0);
        issue("and_ones",   3'b100, ONES,    ONES,      ONES,           1'b1, 1'b0, 1'b0, ~GATED);
        issue("xor_ones",   3'b110, ONES,    64'd0,     ONES,           1'b1, 1'b0, 1'b0, 1'b0);
        issue("add_7fc0",   3'b010, 64'd0,   64'h7FC0,  64'h7FC0,       1'b0, 1'b0, 1'b0, 1'b0);
        issue("op001",      3'b001, 64'd0,   64'h7FC0,  64'd0,          1'b0, 1'b1, 1'b0, 1'b0);
        issue("add_ovf",    3'b010, MAXP,    64'd1,     MSB,            1'b1, 1'b0, 1'b1, 1'b0);
        issue("sub_borrow", 3'b011, 64'd0,   64'd1,     ONES,           1'b1, 1'b0, 1'b0, 1'b0);
        issue("op111",      3'b111, ONES,    ONES,      64'd0,          1'b0, 1'b1, 1'b0, ~GATED);
        issue("sub_ovf",    3'b011, MSB,     64'd1,     MAXP,           1'b0, 1'b0, 1'b1, 1'b1);
        issue("add_wrap",   3'b010, ONES,    64'd2,     64'd1,          1'b0, 1'b0, 1'b0, 1'b1);

        // Mid-cycle reset with nonzero outputs and an operation in flight.
        issue("pre_reset",  3'b011, 64'd3,   64'd2,     64'd1,          1'b0, 1'b0, 1'b0, 1'b1);
        issue("inflight",   3'b010, MSB,     MSB,       64'd0,          1'b0, 1'b1, 1'b1, 1'b1);
        #2;
        reset = 1'b1;
        sb.delete();
        #1 check_now("rst_async", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3 check_now("rst_across_edge", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1 check_now("rst_release", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue("first_after", 3'b110, ONES,   64'd0,     ONES,           1'b1, 1'b0, 1'b0, 1'b0);
        issue("last_or",     3'b101, 64'h00F0, 64'h0F00, 64'h0FF0,      1'b0, 1'b0, 1'b0, 1'b0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses never checked, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_64bit.md
ALU_64BIT -- requirements
Module: alu_64bit

Interface
REQ-001 SHALL provide parameter WIDTH, default 64, datapath width in bits; only 64 is required to be supported.
REQ-002 SHALL provide port clk, input, 1 bit, sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset, input, 1 bit, reset; asynchronous, active-high.
REQ-004 SHALL provide port A, input, 64 bits, first operand.
REQ-005 SHALL provide port B, input, 64 bits, second operand.
REQ-006 SHALL provide port cntrl, input, 3 bits, operation select.
REQ-007 SHALL provide port result, output, 64 bits, registered operation result.
REQ-008 SHALL provide port negative, output, 1 bit, registered copy of result[63].
REQ-009 SHALL provide port zero, output, 1 bit, registered flag: 1 when the computed result is all zeros.
REQ-010 SHALL provide port overflow, output, 1 bit, registered signed-overflow flag.
REQ-011 SHALL provide port carry_out, output, 1 bit, registered carry out of bit 63.

Function
REQ-012 SHALL decode cntrl as follows:
- 000: result = B.
- 010: result = A+B.
- 011: result = A-B.
- 100: result = A&B.
- 101: result = A|B.
- 110: result = A^B.
- 001 and 111: result = 0.
REQ-013 SHALL be built from 64 instances of alu_1bit (inputs a, b, carryIn, selector; outputs carryOut, result), chained with c[j+1] = carryOut of bit j.
REQ-014 SHALL use mux2_1 (2-bit input i, select sel, output out) to drive c[0] = cntrl[0]: carry-in 0 for add, 1 for subtract.
REQ-015 SHALL compute, in every bit slice and for every opcode, the carry chain as the sum of A, (cntrl[0] ? ~B : B) and c[0].
REQ-016 SHALL compute the zero flag with largeOR (input in[63:0], output zeroOutput): zeroOutput = NOR of all 64 bits.
REQ-017 SHALL compute the raw flags as carry = c[64] and overflow = c[64] XOR c[63].
REQ-018 SHALL register result and all four flags together on each rising clk edge, giving a latency of exactly 1 cycle; there is no handshake, and a new operation is accepted every cycle.
REQ-019 SHALL wrap arithmetic modulo 2^64; no saturation.
REQ-020 SHALL compute negative from the computed result[63] for every opcode, including logic ops.

Reset
REQ-021 SHALL, while reset=1, asynchronously force result=0, negative=0, zero=0, overflow=0 and carry_out=0, independent of clk.
REQ-022 SHALL, on reset deassertion, capture the first result at the next rising clk edge.
REQ-023 SHALL discard an operation in flight when reset asserts mid-cycle; it is not replayed.

Configuration
REQ-024 SHALL honour macro ALU_FLAG_GATING_EN:
- Defined: carry_out and overflow are ANDed with "arithmetic" (cntrl[2]=0 AND cntrl[1]=1), so both are 0 for all non-add/sub opcodes.
- Undefined: carry_out and overflow are the raw chain values of REQ-017 for every opcode.

Verification
REQ-025 SHALL pass this check: add with A=B=0x8000_0000_0000_0000 -> next cycle result=0, zero=1, carry_out=1, overflow=1, negative=0.
REQ-026 SHALL pass this check: sub 3-2 -> result=1, carry_out=1, overflow=0, zero=0; sub 1-1 -> result=0, zero=1, carry_out=1.
REQ-027 SHALL pass this check: cntrl=000 with A=B=all-ones -> result=all-ones, negative=1.
- Without macro: carry_out=1, overflow=0.
- With ALU_FLAG_GATING_EN: carry_out=0, overflow=0.
REQ-028 SHALL pass this check: OR with A=0, B=all-ones -> all-ones; AND with A=B=all-ones -> all-ones; XOR with A=all-ones, B=0 -> all-ones, negative=1.
REQ-029 SHALL pass this check: add with A=0, B=0x7FC0 -> result=0x7FC0, zero=0; cntrl=001 -> result=0, zero=1.
REQ-030 SHALL pass this check: assert reset between clk edges while the outputs are nonzero -> all outputs become 0 immediately, and stay 0 until the first edge after release.
